// File: rtl/dmem_bridge_if.sv
// Data-RAM request/acknowledge bus between the MEM-stage bridge and the RAM.
//   ram_req   : request, held high until ram_ack
//   ram_we    : 1 = write, 0 = read
//   ram_addr  : word address
//   ram_wdata : write data
//   ram_ack   : single-cycle completion pulse from the RAM
//   ram_rdata : read data, valid together with ram_ack
// master = bridge side, slave = RAM side.
interface dmem_bridge_if;
  logic        ram_req;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_ack, ram_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// MEM-stage data-memory bridge. Turns the pipeline's load/store request into a
// req/ack transaction on a variable-latency data RAM and returns the load data.
// The MEM stage is stalled until the access completes. Misaligned word
// accesses and RAM timeouts are flagged with sticky error bits.
//   clk, rst_n   : clock, asynchronous active-low reset
//   mem_ren      : load request
//   mem_wen      : store request (wins if both are set)
//   mem_addr     : byte address
//   mem_dout     : store data
//   mem_din      : load data, valid while in DONE
//   mem_stall    : hold IF..MEM this cycle
//   ram          : RAM request/acknowledge bus (master side)
//   align_err    : sticky, misaligned access seen
//   timeout_err  : sticky, RAM timeout seen
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_ren,
  input  logic                mem_wen,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_dout,
  output logic [31:0]         mem_din,
  output logic                mem_stall,
  dmem_bridge_if.master       ram,
  output logic                align_err,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             acc;

  assign acc = mem_ren | mem_wen;

  // Gated by rst_n so the pipeline is released while reset is held, even if
  // a request is still presented.
  always_comb begin
    mem_stall = 1'b0;
    if (rst_n) begin
      mem_stall = ((state == IDLE) && acc) || (state == BUSY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ram.ram_req   <= 1'b0;
      ram.ram_we    <= 1'b0;
      ram.ram_addr  <= '0;
      ram.ram_wdata <= '0;
      mem_din       <= '0;
      align_err     <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            if (mem_addr[1:0] == 2'b00) begin
              ram.ram_req   <= 1'b1;
              ram.ram_we    <= mem_wen;
              ram.ram_addr  <= mem_addr[31:2];
              ram.ram_wdata <= mem_dout;
              cnt           <= '0;
              state         <= BUSY;
            end else begin
              align_err <= 1'b1;
              mem_din   <= '0;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          // An ack arriving in the final allowed cycle still completes normally.
          if (ram.ram_ack) begin
            ram.ram_req <= 1'b0;
            mem_din     <= ram.ram_we ? '0 : ram.ram_rdata;
            state       <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            ram.ram_req <= 1'b0;
            timeout_err <= 1'b1;
            mem_din     <= '1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
